// File: rtl/mem8x8_pkg.sv
// Shared types and constants for the 8x8 bitcell array access controller.
package mem8x8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam int   DEF_WORDS = 8;
  localparam int   DEF_WIDTH = 8;

endpackage

// File: rtl/mem8x8_word_dec.sv
// Address to one-hot word select decoder with enable and out-of-range flag.
module mem8x8_word_dec
  import mem8x8_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int AW    = 3
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WORDS-1:0] sel_o,
  output logic             oor_o
);

  always_comb begin
    oor_o = 32'(addr_i) >= 32'(WORDS);
    sel_o = '0;
    if (en_i && !oor_o) begin
      sel_o = WORDS'(1) << addr_i;
    end
  end

endmodule

// File: rtl/mem8x8_access_ctrl.sv
// Single-word read/write initiator for the bitcell array: setup, strobe
// and hold phases around a one-hot word select, registered outputs.
module mem8x8_access_ctrl
  import mem8x8_pkg::*;
#(
  parameter int WORDS      = DEF_WORDS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STROBE_CYC = 2,
  parameter int AW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [WORDS-1:0] arr_sel,
  output logic             arr_rw,
  output logic [WIDTH-1:0] arr_din,
  input  logic [WIDTH-1:0] arr_dout
);

  localparam int CW = $clog2(STROBE_CYC + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WORDS-1:0] sel_q, sel_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;

  logic [AW-1:0]    dec_addr;
  logic             dec_en;
  logic [WORDS-1:0] dec_sel;
  logic             dec_oor;

  // In IDLE the decoder screens the incoming address; afterwards the held one.
  assign dec_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign dec_en   = (state_q == SETUP)
                 || (state_q == STROBE && cnt_q != CW'(1));

  mem8x8_word_dec #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_dec (
    .en_i   (dec_en),
    .addr_i (dec_addr),
    .sel_o  (dec_sel),
    .oor_o  (dec_oor)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cap_d   = cap_q;
    sel_d   = dec_sel;
    rw_d    = rw_q;
    din_d   = din_q;
    vld_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          we_d   = req_we;
          addr_d = req_addr;
          if (dec_oor) begin
            state_d = DONE;
            vld_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = SETUP;
            rw_d    = req_we ? RW_WRITE : RW_READ;
            din_d   = req_we ? req_wdata : '0;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CW'(STROBE_CYC);
      end
      STROBE: begin
        if (cnt_q == CW'(1)) begin
          state_d = HOLD;
          cap_d   = arr_dout;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        state_d = DONE;
        vld_d   = 1'b1;
        rdata_d = we_q ? '0 : cap_q;
        rw_d    = RW_READ;
        din_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_d = (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cap_q   <= '0;
      sel_q   <= '0;
      rw_q    <= RW_READ;
      din_q   <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cap_q   <= cap_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign arr_sel   = sel_q;
  assign arr_rw    = rw_q;
  assign arr_din   = din_q;

endmodule

// File: tb/tb_mem8x8_access_ctrl.sv
// Scoreboard bench for mem8x8_access_ctrl with a behavioural 6-word array.
module tb_mem8x8_access_ctrl;

  localparam int WORDS = 6;
  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic [WORDS-1:0] arr_sel;
  logic             arr_rw;
  logic [WIDTH-1:0] arr_din;
  logic [WIDTH-1:0] arr_dout;

  mem8x8_access_ctrl #(
    .WORDS      (WORDS),
    .WIDTH      (WIDTH),
    .STROBE_CYC (S),
    .AW         (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .arr_sel   (arr_sel),
    .arr_rw    (arr_rw),
    .arr_din   (arr_din),
    .arr_dout  (arr_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [WORDS] = '{default: 8'h00};
  logic [7:0] ref_m [8]   = '{default: 8'h00};

  always @(posedge clk) begin
    for (int k = 0; k < WORDS; k++)
      if (arr_sel[k] && arr_rw == 1'b0) mem[k] <= arr_din;
  end

  always_comb begin
    arr_dout = '0;
    for (int k = 0; k < WORDS; k++)
      if (arr_sel[k] && arr_rw) arr_dout = arr_dout | mem[k];
  end

  typedef struct {
    logic [7:0] rdata;
    bit         err;
    int         acc;
    int         sel0;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int sel_tot = 0;
  int acc_cyc = 0;
  bit cur_we = 1'b0;
  int cur_addr = 0;
  logic [7:0] cur_d = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit               prev_rst = 1'b0;
  logic [WORDS-1:0] prev_sel = '0;
  logic             prev_rw = 1'b1;
  logic [7:0]       prev_din = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && prev_rst) begin
      if (arr_sel != '0) begin
        sel_tot++;
        chk("sel_onehot", 32'(arr_sel), 32'(WORDS'(1) << cur_addr));
        chk("sel_rw", 32'(arr_rw), cur_we ? 0 : 1);
        chk("sel_din", 32'(arr_din), cur_we ? 32'(cur_d) : 0);
      end
      if (arr_sel != prev_sel) begin
        chk("rw_stable", 32'(arr_rw), 32'(prev_rw));
        chk("din_stable", 32'(arr_din), 32'(prev_din));
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 0);
        end else begin
          e = q.pop_front();
          chk("rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("err", 32'(rsp_err), 32'(e.err));
          chk("latency", cyc - e.acc + 1, e.err ? 1 : S + 3);
          chk("sel_cycles", sel_tot - e.sel0, e.err ? 0 : S);
        end
      end
    end
    prev_rst = rst_n;
    prev_sel = arr_sel;
    prev_rw  = arr_rw;
    prev_din = arr_din;
  end

  task automatic issue(input bit we, input int addr, input logic [7:0] d,
                       input bit keep);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.err   = (addr >= WORDS);
    e.rdata = (e.err || we) ? 8'h00 : ref_m[addr];
    e.acc   = cyc;
    e.sel0  = sel_tot;
    if (!e.err && we) ref_m[addr] = d;
    cur_we   = we;
    cur_addr = addr;
    cur_d    = we ? d : 8'h00;
    acc_cyc  = cyc;
    q.push_back(e);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int prev;
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_sel", 32'(arr_sel), 0);
    chk("rst_rw", 32'(arr_rw), 1);
    chk("rst_din", 32'(arr_din), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_err", 32'(rsp_err), 0);

    issue(1'b1, 3, 8'hA5, 1'b0);
    drain();
    issue(1'b0, 3, 8'h00, 1'b0);
    drain();

    prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, i, 8'h10 + 8'(i), 1'b1);
      if (i > 0) chk("b2b_gap", acc_cyc - prev, S + 4);
      prev = acc_cyc;
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) issue(1'b0, i, 8'h00, 1'b0);
    drain();

    issue(1'b0, 7, 8'h00, 1'b0);
    drain();
    issue(1'b1, 6, 8'hFF, 1'b0);
    drain();
    issue(1'b0, 5, 8'h00, 1'b0);
    drain();

    issue(1'b0, 2, 8'h00, 1'b0);
    n = 0;
    while (arr_sel == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", 32'(arr_sel != '0), 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_sel", 32'(arr_sel), 0);
    chk("midrst_valid", 32'(rsp_valid), 0);
    q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_rw", 32'(arr_rw), 1);

    repeat (40) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            8'($urandom), 1'b0);
    end
    drain();
    for (int i = 0; i < WORDS; i++) issue(1'b0, i, 8'h00, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
